// File: rtl/addr_gen_nd.sv
// -----------------------------------------------------------------------------
// addr_gen_nd
// N-dimensional affine address generator. On i_start it captures a base
// address plus per-dimension extents and strides, then streams one address per
// accepted beat (dimension 0 innermost) and pulses o_done after the last beat.
//
// Optional feature macro: ADDR_GEN_ND_REPEAT_EN
//   When defined, adds i_repeat (sampled with i_start). A latched repeat makes
//   the walk loop back to the base forever, pulsing o_done after every pass;
//   only i_rst ends it.
//
// Ports
//   i_clk          clock, all state on rising edge
//   i_rst          synchronous active-high reset
//   i_start        begin a walk (honoured only in IDLE)
//   i_cfg_base     first address
//   i_cfg_extent   DIMS x CNT_W iterations per dimension (0 acts as 1)
//   i_cfg_stride   DIMS x ADDR_W two's-complement increment per dimension
//   i_repeat       (ADDR_GEN_ND_REPEAT_EN only) loop the walk
//   o_addr         current address (registered)
//   o_addr_valid   o_addr is valid
//   i_addr_ready   consumer accepts o_addr
//   o_addr_last    current beat is the last of the pass
//   o_busy         walk in progress
//   o_done         one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module addr_gen_nd #(
   parameter int ADDR_W = 32,
   parameter int DIMS   = 3,
   parameter int CNT_W  = 16
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_start,
   input  logic [ADDR_W-1:0]      i_cfg_base,
   input  logic [DIMS*CNT_W-1:0]  i_cfg_extent,
   input  logic [DIMS*ADDR_W-1:0] i_cfg_stride,
`ifdef ADDR_GEN_ND_REPEAT_EN
   input  logic                   i_repeat,
`endif
   output logic [ADDR_W-1:0]      o_addr,
   output logic                   o_addr_valid,
   input  logic                   i_addr_ready,
   output logic                   o_addr_last,
   output logic                   o_busy,
   output logic                   o_done
);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t                        r_state;
   logic [ADDR_W-1:0]             r_base;
   logic [DIMS-1:0][CNT_W-1:0]    r_emax;    // effective extent minus one
   logic [DIMS-1:0][ADDR_W-1:0]   r_stride;
   logic [DIMS-1:0][CNT_W-1:0]    r_cnt;
   logic [DIMS-1:0][ADDR_W-1:0]   r_off;
   logic [ADDR_W-1:0]             r_addr;
   logic                          r_valid;
   logic                          r_busy;
   logic                          r_done;

   logic [DIMS-1:0][CNT_W-1:0]    w_emax_cfg;
   logic [DIMS-1:0][ADDR_W-1:0]   w_stride_cfg;
   logic [DIMS-1:0][CNT_W-1:0]    w_cnt_nxt;
   logic [DIMS-1:0][ADDR_W-1:0]   w_off_nxt;
   logic [ADDR_W-1:0]             w_sum;
   logic                          w_found;
   logic                          w_beat;
   logic                          w_last;
   logic                          w_rep;

   // Unpack config slices; an extent of 0 behaves like 1, so its max count is 0.
   genvar g;
   generate
      for (g = 0; g < DIMS; g++) begin : g_cfg
         logic [CNT_W-1:0] w_ext;
         assign w_ext           = i_cfg_extent[g*CNT_W +: CNT_W];
         assign w_emax_cfg[g]   = (w_ext == '0) ? '0 : w_ext - CNT_W'(1);
         assign w_stride_cfg[g] = i_cfg_stride[g*ADDR_W +: ADDR_W];
      end
   endgenerate

`ifdef ADDR_GEN_ND_REPEAT_EN
   logic r_repeat;
   always_ff @(posedge i_clk) begin
      if (i_rst)
         r_repeat <= 1'b0;
      else if (r_state == S_IDLE && i_start)
         r_repeat <= i_repeat;
   end
   assign w_rep = r_repeat;
`else
   assign w_rep = 1'b0;
`endif

   // Odometer step: the lowest dimension not at its max advances, all lower
   // dimensions wrap to zero. If none can advance (final beat) everything
   // wraps, which is exactly the reload state for a repeating walk.
   always_comb begin
      w_found   = 1'b0;
      w_cnt_nxt = r_cnt;
      w_off_nxt = r_off;
      for (int j = 0; j < DIMS; j++) begin
         if (!w_found) begin
            if (r_cnt[j] != r_emax[j]) begin
               w_cnt_nxt[j] = r_cnt[j] + CNT_W'(1);
               w_off_nxt[j] = r_off[j] + r_stride[j];
               w_found      = 1'b1;
            end else begin
               w_cnt_nxt[j] = '0;
               w_off_nxt[j] = '0;
            end
         end
      end
      w_sum = r_base;
      for (int j = 0; j < DIMS; j++)
         w_sum = w_sum + w_off_nxt[j];
   end

   assign w_last = (r_state == S_RUN) && !w_found;
   assign w_beat = r_valid && i_addr_ready;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_base   <= '0;
         r_emax   <= '0;
         r_stride <= '0;
         r_cnt    <= '0;
         r_off    <= '0;
         r_addr   <= '0;
         r_valid  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_base   <= i_cfg_base;
                  r_emax   <= w_emax_cfg;
                  r_stride <= w_stride_cfg;
                  r_cnt    <= '0;
                  r_off    <= '0;
                  r_addr   <= i_cfg_base;
                  r_valid  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_state  <= S_RUN;
               end
            end
            S_RUN: begin
               if (w_beat) begin
                  r_cnt <= w_cnt_nxt;
                  r_off <= w_off_nxt;
                  if (w_last && !w_rep) begin
                     // single pass finished; address holds its last value
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_addr <= w_sum;
                     r_done <= w_last;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_addr       = r_addr;
   assign o_addr_valid = r_valid;
   assign o_addr_last  = w_last;
   assign o_busy       = r_busy;
   assign o_done       = r_done;

endmodule

// File: tb/tb_addr_gen_nd.sv
module tb_addr_gen_nd;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] cfg_base;
   logic [47:0] cfg_extent;
   logic [95:0] cfg_stride;
   logic        ready;
   logic        rpt;
   logic [31:0] addr;
   logic        valid, last, busy, done;

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] got [0:63];
   int          nb, lidx;

   always #5 clk = ~clk;

   addr_gen_nd #(.ADDR_W(32), .DIMS(3), .CNT_W(16)) dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_start      (start),
      .i_cfg_base   (cfg_base),
      .i_cfg_extent (cfg_extent),
      .i_cfg_stride (cfg_stride),
`ifdef ADDR_GEN_ND_REPEAT_EN
      .i_repeat     (rpt),
`endif
      .o_addr       (addr),
      .o_addr_valid (valid),
      .i_addr_ready (ready),
      .o_addr_last  (last),
      .o_busy       (busy),
      .o_done       (done)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called #1 after an edge; start is seen at the next edge.
   task automatic do_start(input logic [31:0] b, input logic [47:0] e, input logic [95:0] s);
      start = 1'b1; cfg_base = b; cfg_extent = e; cfg_stride = s;
      tick();
      start = 1'b0;
      check("start_valid", valid, 1);
      check("start_busy", busy, 1);
      check("start_addr", addr, b);
   endtask

   // pat 0: ready always 1; pat 1: ready 1,0,0,1,0,0...
   // poke: pulse start with a different base mid-walk (must be ignored).
   task automatic collect(input int pat, input bit poke);
      logic [31:0] prev;
      bit stalled, fin;
      nb = 0; lidx = -1; stalled = 0; prev = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         ready = (pat == 0) ? 1'b1 : (cyc % 3 == 0);
         if (poke && cyc == 2) begin
            start = 1'b1; cfg_base = 32'h900;
         end else start = 1'b0;
         if (stalled) check("hold_addr", addr, prev);
         if (!valid) begin
            check("valid_mid_walk", valid, 1);
            return;
         end
         fin = ready && last;
         if (ready) begin
            got[nb] = addr;
            if (last) lidx = nb;
            nb++;
         end
         prev = addr; stalled = !ready;
         tick();
         start = 1'b0;
         if (fin) begin
            ready = 1'b0;
            check("done_pulse", done, 1);
            check("done_busy", busy, 0);
            check("done_valid", valid, 0);
            check("done_addr_hold", addr, prev);
            return;
         end
         if (nb >= 64) begin
            check("beat_overrun", nb, 0);
            return;
         end
      end
      check("walk_timeout", 0, 1);
   endtask

   logic [31:0] exp1 [0:11] = '{32'h100, 32'h101, 32'h102, 32'h103,
                                32'h110, 32'h111, 32'h112, 32'h113,
                                32'h120, 32'h121, 32'h122, 32'h123};
   logic [31:0] exp4 [0:4]  = '{32'h0, 32'hFFFFFFFC, 32'hFFFFFFF8,
                                32'hFFFFFFF4, 32'hFFFFFFF0};

   localparam logic [47:0] EXT1 = {16'd0, 16'd3, 16'd4};
   localparam logic [95:0] STR1 = {32'd0, 32'h10, 32'h1};

   task automatic cmp_walk1(input string tag);
      check({tag, "_count"}, nb, 12);
      check({tag, "_last_idx"}, lidx, 11);
      for (int i = 0; i < 12 && i < nb; i++)
         check($sformatf("%s_addr%0d", tag, i), got[i], exp1[i]);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_extent = '0; cfg_stride = '0;
      ready = 1'b0; rpt = 1'b0;
      repeat (3) tick();
      check("rst_addr", addr, 0);
      check("rst_valid", valid, 0);
      check("rst_last", last, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      rst = 1'b0;
      tick();

      // 2D scan, ready held high
      do_start(32'h100, EXT1, STR1);
      collect(0, 0);
      cmp_walk1("w1");
      tick();
      check("w1_done_once", done, 0);

      // same scan with back-pressure; next walk starts in the done cycle
      do_start(32'h100, EXT1, STR1);
      collect(1, 0);
      cmp_walk1("w2");

      // all extents zero: one beat
      do_start(32'hABC, 48'd0, {32'd7, 32'd7, 32'd7});
      check("w3_last", last, 1);
      collect(0, 0);
      check("w3_count", nb, 1);
      check("w3_addr", got[0], 32'hABC);
      tick();

      // negative stride wraps modulo 2^32
      do_start(32'h0, {16'd0, 16'd0, 16'd5}, {32'd0, 32'd0, 32'hFFFFFFFC});
      collect(0, 0);
      check("w4_count", nb, 5);
      check("w4_last_idx", lidx, 4);
      for (int i = 0; i < 5 && i < nb; i++)
         check($sformatf("w4_addr%0d", i), got[i], exp4[i]);
      tick();

      // reset mid-walk after 5 beats, with a simultaneous start
      do_start(32'h100, EXT1, STR1);
      ready = 1'b1;
      repeat (5) tick();
      check("pre_rst_addr", addr, 32'h111);
      rst = 1'b1; start = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; ready = 1'b0;
      check("mrst_valid", valid, 0);
      check("mrst_addr", addr, 0);
      check("mrst_busy", busy, 0);
      check("mrst_done", done, 0);
      tick();
      check("mrst_done2", done, 0);
      check("mrst_valid2", valid, 0);

      // clean restart, with an ignored start pulse mid-walk
      do_start(32'h100, EXT1, STR1);
      collect(0, 1);
      cmp_walk1("w5");
      tick();

`ifdef ADDR_GEN_ND_REPEAT_EN
      begin
         logic [31:0] rexp [0:3];
         rexp = '{32'd0, 32'd1, 32'd4, 32'd5};
         rpt = 1'b1;
         do_start(32'h0, {16'd0, 16'd2, 16'd2}, {32'd0, 32'd4, 32'd1});
         rpt = 1'b0;
         ready = 1'b1;
         for (int i = 0; i < 10; i++) begin
            check($sformatf("rep_addr%0d", i), addr, rexp[i % 4]);
            check($sformatf("rep_valid%0d", i), valid, 1);
            check($sformatf("rep_busy%0d", i), busy, 1);
            check($sformatf("rep_done%0d", i), done, (i > 0 && i % 4 == 0));
            tick();
         end
         rst = 1'b1;
         tick();
         rst = 1'b0; ready = 1'b0;
         check("rep_rst_valid", valid, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/addr_gen_nd.md
# addr_gen_nd

Parametrised N-dimensional affine address generator, the successor to the fixed two-level scan counter chain used for 2D address streams. On `start` it latches a base address, per-dimension extents and per-dimension strides. It then emits one address per accepted beat on a valid/ready stream, walking dimension 0 innermost, and signals completion. It sits between the scheduler and a memory port's address input.

## Interface
Parameters:
- `ADDR_W`, 32, address and stride width
- `DIMS`, 3, number of nested loop dimensions (1..8)
- `CNT_W`, 16, extent/counter width per dimension

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  begin a walk; sampled only in IDLE
- `cfg_base`  in  ADDR_W  first address
- `cfg_extent`  in  DIMS*CNT_W  iterations per dimension; slice j = bits [j*CNT_W +: CNT_W]
- `cfg_stride`  in  DIMS*ADDR_W  two's-complement address increment per step of dimension j
- `addr`  out  ADDR_W  current address
- `addr_valid`  out  1  `addr` is valid
- `addr_ready`  in  1  consumer accepts `addr`
- `addr_last`  out  1  current beat is the final address of the walk
- `busy`  out  1  walk in progress
- `done`  out  1  one-cycle pulse after the final beat is accepted

## Operation
- There are two states, IDLE and RUN. Reset enters IDLE with `addr`=0, `addr_valid`=0, `addr_last`=0, `busy`=0, `done`=0, and all counters and offsets 0.
- IDLE with `start`=1 does the following:
  - latches the cfg inputs into internal registers;
  - clears counters `cnt[j]` and offsets `off[j]`;
  - loads `addr`=`cfg_base`;
  - enters RUN with `addr_valid`=1 and `busy`=1.
- Config inputs are ignored outside the start cycle. `start` in RUN is ignored.
- Effective extent `e[j]` = `cfg_extent` slice, with a value of 0 treated as 1.
- A beat fires when `addr_valid` && `addr_ready`. On a beat, find the lowest k with `cnt[k]` != `e[k]`-1:
  - `cnt[k]`++ and `off[k]` += `stride[k]`;
  - for every j<k, `cnt[j]`=0 and `off[j]`=0;
  - next `addr` = `base` + Σ `off[j]` after the update.
- All address arithmetic is modulo 2^ADDR_W. Negative strides wrap naturally.
- `addr_last` = 1 when every `cnt[j]` == `e[j]`-1 and the state is RUN.
- A beat with `addr_last`=1 ends the walk:
  - next cycle: IDLE, `addr_valid`=0, `busy`=0, `done`=1;
  - `addr` holds its last value.
- When no beat fires (`addr_ready`=0), `addr`, `addr_valid`, `addr_last` and all counters hold. `addr_valid` never drops mid-walk.
- Total beats per walk = Π `e[j]`.

## Timing
- `start` sampled at edge T: first address visible after T, so `addr_valid`=1 in cycle T+1.
- Throughput is 1 address/cycle with `addr_ready` held high. There are no bubbles at dimension wraps.
- Final beat accepted at edge F: `done`=1 and `busy`=0 during cycle F+1. `done` is high for exactly one cycle.
- `start` may be asserted in cycle F+1, the cycle `done` is high, since the block is IDLE. The next walk's first address then appears at F+2.
- `rst` at any edge overrides everything, including mid-walk and a simultaneous `start`. The block is in IDLE with reset values the next cycle, and no `done` is produced.
- The `addr` register drives the output directly, with no combinational path from `addr_ready` to `addr`. `addr_valid` and `addr_last` are registered or decoded from registered state only.

## Configuration
- `ADDR_GEN_ND_REPEAT_EN` defined:
  - adds input port `repeat` (1 bit), sampled at `start`;
  - when latched high, the final beat reloads `addr`=`base` and clears the counters, with no IDLE gap;
  - `done` pulses one cycle after every completed pass and `busy` stays 1;
  - the walk ends only on `rst`.
- Macro undefined: no `repeat` port, and each walk is single-pass as described above.

## Test plan
- DIMS=2, base 0x100, extents {4,3}, strides {1,0x10}, ready=1 -> 12 consecutive addresses 0x100–0x103, 0x110–0x113, 0x120–0x123. `addr_last` only on 0x123, then `done` pulse and `busy`=0.
- Same config with `addr_ready` toggling 1,0,0,1… -> the same 12-address sequence, `addr` stable while ready=0, no beat lost or duplicated.
- DIMS=3, all extents 0 -> a single beat at `cfg_base` with `addr_last`=1, then `done`.
- base 0x0, extent {5}, stride 0xFFFFFFFC -> 0x0, 0xFFFFFFFC, 0xFFFFFFF8, 0xFFFFFFF4, 0xFFFFFFF0.
- Assert `rst` at beat 6 of the first scenario -> `addr_valid`=0 and `addr`=0 next cycle, no `done`. A later `start` restarts cleanly at 0x100. A `start` pulse mid-walk has no effect.
- With `ADDR_GEN_ND_REPEAT_EN` and repeat=1, extents {2,2}, strides {1,4}, base 0 -> 0,1,4,5,0,1,4,5… back-to-back, `done` pulsed after each 5.
